aurora_link_supervisor: RTL
===========================

Name: aurora_link_supervisor

Overview:
Parametrised reset sequencer and link supervisor for one Aurora core, clocked on init_clk. It drives gt_reset and the core reset in two timed phases, then waits for a stable, synchronised channel_up before releasing reset_tx_rx_block to the TX/RX data-path blocks. Unlike a fixed power-on sequencer, it re-initialises the link on timeout, on channel_up loss, or on a restart request. It also counts retries and link drops, and latches a failure flag after MAX_RETRIES.

Parameters:
GT_RESET_CYCLES, 64, init_clk cycles gt_reset held high (>=1)
CORE_RESET_CYCLES, 32, cycles reset_aurora stays high after gt_reset drops (>=1)
UP_STABLE_CYCLES, 8, consecutive synced channel_up=1 samples required before link declared up (>=1)
UP_TIMEOUT_CYCLES, 4096, max cycles in WAIT_UP before retry (> UP_STABLE_CYCLES)
DOWN_FILTER_CYCLES, 4, consecutive synced channel_up=0 samples that declare link loss (>=1)
MAX_RETRIES, 3, timeouts tolerated before FAIL (1..255)
SYNC_STAGES, 2, channel_up synchroniser depth (>=2)
CNT_W, 16, phase/timeout counter width; every cycle parameter must be < 2^CNT_W

Ports:
init_clk  in  1  sequencer clock
RST  in  1  synchronous, active-high reset
channel_up  in  1  Aurora CORE_STATUS channel_up, asynchronous to init_clk
restart  in  1  single-cycle request to re-run the full sequence
gt_reset  out  1  to Aurora gt_reset
reset_aurora  out  1  to Aurora reset
reset_tx_rx_block  out  1  active-high reset to Aurora_to_FIFO / FIFO_to_Aurora
link_ok  out  1  high while in LINK_UP
init_fail  out  1  high while in FAIL
retry_count  out  8  WAIT_UP timeouts since last RST/restart, saturating at 255
link_drop_count  out  8  LINK_UP->GT_RST transitions since RST, saturating at 255
state  out  3  0 GT_RST, 1 CORE_RST, 2 WAIT_UP, 3 LINK_UP, 4 FAIL

Behaviour:
- All outputs are registered. RST dominates everything.
- While RST=1, the following values hold:
  - gt_reset=1, reset_aurora=1, reset_tx_rx_block=1
  - link_ok=0, init_fail=0, retry_count=0, link_drop_count=0
  - state=GT_RST, all counters=0, synchroniser flops=0
- channel_up passes through SYNC_STAGES flops; only the last flop (up_s) is used.
- A single phase counter clears on every state entry.
- GT_RST: gt_reset=1, reset_aurora=1. Exits to CORE_RST after exactly GT_RESET_CYCLES cycles. gt_reset is high for exactly GT_RESET_CYCLES cycles counted from the first edge with RST=0.
- CORE_RST: gt_reset=0, reset_aurora=1. Exits to WAIT_UP after exactly CORE_RESET_CYCLES cycles.
- WAIT_UP: gt_reset=0, reset_aurora=0, reset_tx_rx_block=1.
  - A stable counter increments while up_s=1 and clears on up_s=0.
  - When it reaches UP_STABLE_CYCLES, go to LINK_UP.
  - If the phase counter reaches UP_TIMEOUT_CYCLES first, increment retry_count. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to GT_RST.
  - If stable completion and timeout occur in the same cycle, stable wins.
- LINK_UP: reset_tx_rx_block=0, link_ok=1.
  - A down counter increments while up_s=0 and clears on up_s=1.
  - At DOWN_FILTER_CYCLES, go to GT_RST and increment link_drop_count. retry_count is unchanged.
  - Shorter glitches are ignored.
  - reset_tx_rx_block asserts on the same edge that state leaves LINK_UP.
- FAIL: gt_reset=1, reset_aurora=1, reset_tx_rx_block=1, init_fail=1. The block stays here until RST or restart.
- restart=1 (RST=0), in any state: go to GT_RST next edge, clear retry_count and init_fail; link_drop_count is kept. restart overrides any same-cycle channel_up-driven transition.
- Latency from a clean channel_up rise (WAIT_UP) to reset_tx_rx_block=0 is SYNC_STAGES+UP_STABLE_CYCLES+1 cycles, tolerance +1 for CDC sampling.
- reset_tx_rx_block=0 only in LINK_UP; link_ok is its exact complement.

Test Plan:
- RST high 5 cycles then low, channel_up=1 throughout -> gt_reset high exactly 64 cycles; reset_aurora falls 32 cycles later; reset_tx_rx_block falls 11 (+1) cycles after that; link_ok=1, state=3.
- channel_up toggles 1,0,1 with 3-cycle pulses in WAIT_UP, then steady 1 -> no LINK_UP until 8 consecutive synced highs; stable counter restarts on each drop.
- channel_up=0 forever -> 3 timeouts of 4096 cycles; retry_count=1,2,3; then state=4, init_fail=1, gt_reset=1, reset_tx_rx_block=1 held.
- In LINK_UP, channel_up drop of 2 cycles -> no change. Drop of 10 cycles -> state=0 after 4 synced low samples, reset_tx_rx_block=1 same edge, link_drop_count=1, full sequence reruns.
- From FAIL, pulse restart -> state=0 next edge, init_fail=0, retry_count=0, link_drop_count preserved; restart and RST together -> RST values win.
- RST asserted mid-CORE_RST and mid-LINK_UP -> all outputs return to reset values next edge; counters and both statistics clear.

Source files
------------

// File: rtl/aurora_link_supervisor.sv
// Reset sequencer and link supervisor for one Aurora core: timed gt/core reset phases,
// filtered channel_up qualification, retry/timeout handling and link-drop statistics.
module aurora_link_supervisor #(
   parameter int unsigned GT_RESET_CYCLES    = 64,
   parameter int unsigned CORE_RESET_CYCLES  = 32,
   parameter int unsigned UP_STABLE_CYCLES   = 8,
   parameter int unsigned UP_TIMEOUT_CYCLES  = 4096,
   parameter int unsigned DOWN_FILTER_CYCLES = 4,
   parameter int unsigned MAX_RETRIES        = 3,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned CNT_W              = 16
) (
   input  logic       init_clk,
   input  logic       RST,
   input  logic       channel_up,
   input  logic       restart,
   output logic       gt_reset,
   output logic       reset_aurora,
   output logic       reset_tx_rx_block,
   output logic       link_ok,
   output logic       init_fail,
   output logic [7:0] retry_count,
   output logic [7:0] link_drop_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StGtRst   = 3'd0,
      StCoreRst = 3'd1,
      StWaitUp  = 3'd2,
      StLinkUp  = 3'd3,
      StFail    = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] GtLast      = CNT_W'(GT_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CoreLast    = CNT_W'(CORE_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(UP_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] StableN     = CNT_W'(UP_STABLE_CYCLES);
   localparam logic [CNT_W-1:0] DownN       = CNT_W'(DOWN_FILTER_CYCLES);
   localparam logic [7:0]       MaxRetries  = 8'(MAX_RETRIES);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       phase_q, phase_d;
   logic [CNT_W-1:0]       run_q, run_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [7:0]             retry_q, retry_d;
   logic [7:0]             drop_q, drop_d;
   logic                   gt_reset_q, gt_reset_d;
   logic                   reset_aurora_q, reset_aurora_d;
   logic                   reset_txrx_q, reset_txrx_d;
   logic                   link_ok_q, link_ok_d;
   logic                   init_fail_q, init_fail_d;
   logic                   up_s;

   assign up_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], channel_up};
      state_d = state_q;
      phase_d = phase_q + 1'b1;
      run_d   = run_q;
      retry_d = retry_q;
      drop_d  = drop_q;

      unique case (state_q)
         StGtRst: begin
            if (phase_q == GtLast) state_d = StCoreRst;
         end
         StCoreRst: begin
            if (phase_q == CoreLast) state_d = StWaitUp;
         end
         StWaitUp: begin
            run_d = up_s ? run_q + 1'b1 : '0;
            // Stable completion takes priority over a same-cycle timeout.
            if (run_q == StableN) begin
               state_d = StLinkUp;
            end else if (phase_q == TimeoutLast) begin
               if (retry_q != 8'hff) retry_d = retry_q + 1'b1;
               state_d = (retry_d == MaxRetries) ? StFail : StGtRst;
            end
         end
         StLinkUp: begin
            run_d = up_s ? '0 : run_q + 1'b1;
            if (run_q == DownN) begin
               state_d = StGtRst;
               if (drop_q != 8'hff) drop_d = drop_q + 1'b1;
            end
         end
         StFail: begin
            phase_d = phase_q;
         end
         default: begin
            state_d = StGtRst;
         end
      endcase

      // restart wins over any same-cycle link-driven transition, including its drop count.
      if (restart) begin
         state_d = StGtRst;
         retry_d = '0;
         drop_d  = drop_q;
      end

      if (state_d != state_q || restart) begin
         phase_d = '0;
         run_d   = '0;
      end

      gt_reset_d     = (state_d == StGtRst) || (state_d == StFail);
      reset_aurora_d = (state_d == StGtRst) || (state_d == StCoreRst) || (state_d == StFail);
      reset_txrx_d   = (state_d != StLinkUp);
      link_ok_d      = (state_d == StLinkUp);
      init_fail_d    = (state_d == StFail);
   end

   always_ff @(posedge init_clk) begin
      if (RST) begin
         state_q        <= StGtRst;
         phase_q        <= '0;
         run_q          <= '0;
         sync_q         <= '0;
         retry_q        <= '0;
         drop_q         <= '0;
         gt_reset_q     <= 1'b1;
         reset_aurora_q <= 1'b1;
         reset_txrx_q   <= 1'b1;
         link_ok_q      <= 1'b0;
         init_fail_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         run_q          <= run_d;
         sync_q         <= sync_d;
         retry_q        <= retry_d;
         drop_q         <= drop_d;
         gt_reset_q     <= gt_reset_d;
         reset_aurora_q <= reset_aurora_d;
         reset_txrx_q   <= reset_txrx_d;
         link_ok_q      <= link_ok_d;
         init_fail_q    <= init_fail_d;
      end
   end

   assign gt_reset          = gt_reset_q;
   assign reset_aurora      = reset_aurora_q;
   assign reset_tx_rx_block = reset_txrx_q;
   assign link_ok           = link_ok_q;
   assign init_fail         = init_fail_q;
   assign retry_count       = retry_q;
   assign link_drop_count   = drop_q;
   assign state             = state_q;

endmodule
